// File: rtl/dps_pkg.sv
// Shared types and constants for the dynamic phase-shift eye-scan controller.
package dps_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STEP_REQ,
        ST_STEP_WAIT,
        ST_SETTLE,
        ST_SAMPLE,
        ST_EVAL,
        ST_MOVE_REQ,
        ST_MOVE_WAIT
    } dps_state_e;

    localparam int WD_W = 10;
    localparam int unsigned WD_CYCLES = 1024;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_CYCLES - 1);

    localparam int DEF_SCAN_RANGE = 448;
    localparam int DEF_POS_W = $clog2(DEF_SCAN_RANGE + 1);

    // Position/length counters must hold the full range value itself.
    function automatic int pos_width(input int range);
        return $clog2(range + 1);
    endfunction

endpackage

// File: rtl/dps_eye_scan_if.sv
// MMCM dynamic phase-shift handshake: request/direction out, step-complete back.
interface dps_eye_scan_if;
    logic psen;
    logic psincdec;
    logic psdone;

    modport master (output psen, output psincdec, input psdone);
    modport slave  (input psen, input psincdec, output psdone);
endinterface

// File: rtl/dps_win_track.sv
// Run-length tracker for pass/fail positions of one scan; keeps the widest passing
// window and merges a run ending at the last position with the run starting at 0.
module dps_win_track
    import dps_pkg::*;
#(
    parameter int POS_W = DEF_POS_W
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             clear,
    input  logic             valid,
    input  logic             pass,
    input  logic             last,
    output logic [POS_W-1:0] best_start,
    output logic [POS_W-1:0] best_width,
    output logic [POS_W-1:0] first_run_len,
    output logic [POS_W-1:0] cur_run_len
);

    logic [POS_W-1:0] pos_q, pos_d;
    logic [POS_W-1:0] cur_start_q, cur_start_d;
    logic [POS_W-1:0] cur_len_q, cur_len_d;
    logic [POS_W-1:0] first_len_q, first_len_d;
    logic [POS_W-1:0] best_start_q, best_start_d;
    logic [POS_W-1:0] best_width_q, best_width_d;
    logic             first_open_q, first_open_d;
    logic [POS_W-1:0] merged_len;

    always_comb begin
        pos_d        = pos_q;
        cur_start_d  = cur_start_q;
        cur_len_d    = cur_len_q;
        first_len_d  = first_len_q;
        first_open_d = first_open_q;
        best_start_d = best_start_q;
        best_width_d = best_width_q;
        merged_len   = '0;

        if (clear) begin
            pos_d        = '0;
            cur_start_d  = '0;
            cur_len_d    = '0;
            first_len_d  = '0;
            first_open_d = 1'b1;
            best_start_d = '0;
            best_width_d = '0;
        end else if (valid) begin
            pos_d = pos_q + 1'b1;
            if (pass) begin
                cur_len_d = cur_len_q + 1'b1;
                if (cur_len_q == '0) begin
                    cur_start_d = pos_q;
                end
                if (first_open_q) begin
                    first_len_d = first_len_q + 1'b1;
                end
            end else begin
                cur_len_d    = '0;
                first_open_d = 1'b0;
            end

            // Strict compare keeps the earliest start on equal widths.
            if (cur_len_d > best_width_q) begin
                best_width_d = cur_len_d;
                best_start_d = cur_start_d;
            end

            // A run reaching the final position continues into the run at position 0,
            // unless every position passed (then the first run already is the whole range).
            if (last && pass && !first_open_q && (first_len_q != '0)) begin
                merged_len = cur_len_d + first_len_q;
                if (merged_len > best_width_d) begin
                    best_width_d = merged_len;
                    best_start_d = cur_start_d;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            pos_q        <= '0;
            cur_start_q  <= '0;
            cur_len_q    <= '0;
            first_len_q  <= '0;
            first_open_q <= 1'b1;
            best_start_q <= '0;
            best_width_q <= '0;
        end else begin
            pos_q        <= pos_d;
            cur_start_q  <= cur_start_d;
            cur_len_q    <= cur_len_d;
            first_len_q  <= first_len_d;
            first_open_q <= first_open_d;
            best_start_q <= best_start_d;
            best_width_q <= best_width_d;
        end
    end

    assign best_start    = best_start_q;
    assign best_width    = best_width_q;
    assign first_run_len = first_len_q;
    assign cur_run_len   = cur_len_q;

endmodule

// File: rtl/dps_eye_scan.sv
// Dynamic phase-shift controller: signed manual step, or full-period eye scan that parks
// the clock at the centre of the widest passing window. DPS_TIMEOUT_EN adds a psdone watchdog.
module dps_eye_scan
    import dps_pkg::*;
#(
    parameter int              NCH        = 1,
    parameter int              PW         = 16,
    parameter logic [PW-1:0]   PATTERN    = 16'hF0F0,
    parameter int              SCAN_RANGE = 448,
    parameter int              SETTLE_CYC = 16,
    parameter int              SAMPLE_CYC = 64
) (
    input  logic              psclk,
    input  logic              reset,
    input  logic              pscmd,
    input  logic              psmode,
    input  logic [15:0]       psstep,
    input  logic [NCH*PW-1:0] deser_dout,
    dps_eye_scan_if.master    ps,
    output logic              psscan_flag,
    output logic [15:0]       dtcref_phase,
    output logic [15:0]       eye_width,
    output logic              scan_fail,
    output logic              ps_timeout
);

    localparam int               POS_W       = pos_width(SCAN_RANGE);
    localparam logic [POS_W-1:0] POS_LAST    = POS_W'(SCAN_RANGE - 1);
    localparam logic [POS_W-1:0] POS_FULL    = POS_W'(SCAN_RANGE);
    localparam logic [POS_W-1:0] POS_HALF    = POS_W'(SCAN_RANGE / 2);
    localparam logic [POS_W:0]   RANGE_X     = (POS_W+1)'(SCAN_RANGE);
    localparam logic [15:0]      SETTLE_LAST = 16'(SETTLE_CYC - 1);
    localparam logic [15:0]      SAMPLE_LAST = 16'(SAMPLE_CYC - 1);

    dps_state_e       state_q, state_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [POS_W-1:0] p_q, p_d;
    logic             acc_q, acc_d;
    logic [14:0]      move_cnt_q, move_cnt_d;
    logic             incdec_q, incdec_d;
    logic [15:0]      phase_q, phase_d;
    logic [15:0]      eye_q, eye_d;
    logic             fail_q, fail_d;
    logic             flag_q, flag_d;
`ifdef DPS_TIMEOUT_EN
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             timeout_q, timeout_d;
`endif

    logic             accept;
    logic             done_acc;
    logic             tr_clear, tr_valid, tr_pass, tr_last;
    logic [POS_W-1:0] best_start, best_width, first_run_len, cur_run_len;
    logic [POS_W:0]   centre_sum;
    logic [POS_W-1:0] centre;
    logic [NCH-1:0]   ch_match;
    logic             all_match;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            assign ch_match[gi] = (deser_dout[gi*PW +: PW] == PATTERN);
        end
    endgenerate
    assign all_match = &ch_match;

    dps_win_track #(.POS_W(POS_W)) u_track (
        .clk          (psclk),
        .srst         (reset),
        .clear        (tr_clear),
        .valid        (tr_valid),
        .pass         (tr_pass),
        .last         (tr_last),
        .best_start   (best_start),
        .best_width   (best_width),
        .first_run_len(first_run_len),
        .cur_run_len  (cur_run_len)
    );

    logic unused_track;
    assign unused_track = ^{first_run_len, cur_run_len};

    // Centre of the winning window, folded back into the period.
    always_comb begin
        centre_sum = {1'b0, best_start} + {2'b0, best_width[POS_W-1:1]};
        if (best_width == POS_FULL) begin
            centre = POS_HALF;
        end else if (centre_sum >= RANGE_X) begin
            centre = POS_W'(centre_sum - RANGE_X);
        end else begin
            centre = centre_sum[POS_W-1:0];
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        p_d        = p_q;
        acc_d      = acc_q;
        move_cnt_d = move_cnt_q;
        incdec_d   = incdec_q;
        phase_d    = phase_q;
        eye_d      = eye_q;
        fail_d     = fail_q;
        tr_clear   = 1'b0;
        tr_valid   = 1'b0;
        tr_pass    = 1'b0;
        tr_last    = 1'b0;
        done_acc   = 1'b0;
        accept     = (state_q == ST_IDLE) && pscmd && !flag_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (psmode) begin
                        incdec_d = 1'b1;
                        tr_clear = 1'b1;
                        p_d      = '0;
                        cnt_d    = '0;
                        state_d  = ST_SETTLE;
                    end else if (psstep[14:0] != 15'd0) begin
                        incdec_d   = ~psstep[15];
                        move_cnt_d = psstep[14:0];
                        state_d    = ST_MOVE_REQ;
                    end
                end
            end
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    acc_d   = 1'b1;
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_SAMPLE: begin
                acc_d = acc_q & all_match;
                if (cnt_q == SAMPLE_LAST) begin
                    tr_valid = 1'b1;
                    tr_pass  = acc_q & all_match;
                    tr_last  = (p_q == POS_LAST);
                    cnt_d    = '0;
                    state_d  = ST_STEP_REQ;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_STEP_REQ: state_d = ST_STEP_WAIT;
            ST_STEP_WAIT: begin
                if (ps.psdone) begin
                    done_acc = 1'b1;
                    if (p_q == POS_LAST) begin
                        state_d = ST_EVAL;
                    end else begin
                        p_d     = p_q + 1'b1;
                        cnt_d   = '0;
                        state_d = ST_SETTLE;
                    end
                end
            end
            ST_EVAL: begin
                eye_d  = 16'(best_width);
                fail_d = (best_width == '0);
                if ((best_width == '0) || (centre == '0)) begin
                    state_d = ST_IDLE;
                end else begin
                    move_cnt_d = 15'(centre);
                    state_d    = ST_MOVE_REQ;
                end
            end
            ST_MOVE_REQ: state_d = ST_MOVE_WAIT;
            ST_MOVE_WAIT: begin
                if (ps.psdone) begin
                    done_acc   = 1'b1;
                    move_cnt_d = move_cnt_q - 15'd1;
                    state_d    = (move_cnt_q == 15'd1) ? ST_IDLE : ST_MOVE_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (done_acc) begin
            phase_d = incdec_q ? (phase_q + 16'd1) : (phase_q - 16'd1);
        end

`ifdef DPS_TIMEOUT_EN
        wd_d      = '0;
        timeout_d = timeout_q;
        if (accept) begin
            timeout_d = 1'b0;
        end
        if (((state_q == ST_STEP_WAIT) || (state_q == ST_MOVE_WAIT)) && !ps.psdone) begin
            wd_d = wd_q + 1'b1;
            if (wd_q == WD_LAST) begin
                wd_d      = '0;
                timeout_d = 1'b1;
                state_d   = ST_IDLE;
            end
        end
`endif

        // Busy also covers the single cycle of an accepted zero-magnitude step.
        flag_d = (state_d != ST_IDLE) || accept;
    end

    always_ff @(posedge psclk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            p_q        <= '0;
            acc_q      <= 1'b0;
            move_cnt_q <= '0;
            incdec_q   <= 1'b0;
            phase_q    <= '0;
            eye_q      <= '0;
            fail_q     <= 1'b0;
            flag_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            p_q        <= p_d;
            acc_q      <= acc_d;
            move_cnt_q <= move_cnt_d;
            incdec_q   <= incdec_d;
            phase_q    <= phase_d;
            eye_q      <= eye_d;
            fail_q     <= fail_d;
            flag_q     <= flag_d;
        end
    end

`ifdef DPS_TIMEOUT_EN
    always_ff @(posedge psclk) begin
        if (reset) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end
    assign ps_timeout = timeout_q;
`else
    assign ps_timeout = 1'b0;
`endif

    assign ps.psen       = (state_q == ST_STEP_REQ) || (state_q == ST_MOVE_REQ);
    assign ps.psincdec   = incdec_q;
    assign psscan_flag   = flag_q;
    assign dtcref_phase  = phase_q;
    assign eye_width     = eye_q;
    assign scan_fail     = fail_q;

endmodule

// File: tb/tb_dps_eye_scan.sv
// Scoreboard bench for dps_eye_scan: directed step/scan operations against an MMCM and
// deserialiser model; a monitor checks each completed operation when psscan_flag falls.
module tb_dps_eye_scan;

    localparam int          NCH    = 2;
    localparam int          PW     = 16;
    localparam int          SR     = 16;
    localparam int          SETTLE = 4;
    localparam int          SAMPLE = 8;
    localparam logic [15:0] PAT    = 16'hF0F0;

    typedef struct {
        int phase;
        int eye;
        int fail;
        int npsen;
        int dir;
        int tmo;
        int busy;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              pscmd = 1'b0;
    logic              psmode = 1'b0;
    logic [15:0]       psstep = '0;
    logic [NCH*PW-1:0] deser_dout = '0;
    logic              psscan_flag, scan_fail, ps_timeout;
    logic [15:0]       dtcref_phase, eye_width;

    dps_eye_scan_if ps_if ();

    dps_eye_scan #(
        .NCH(NCH), .PW(PW), .PATTERN(PAT), .SCAN_RANGE(SR),
        .SETTLE_CYC(SETTLE), .SAMPLE_CYC(SAMPLE)
    ) dut (
        .psclk       (clk),
        .reset       (reset),
        .pscmd       (pscmd),
        .psmode      (psmode),
        .psstep      (psstep),
        .deser_dout  (deser_dout),
        .ps          (ps_if),
        .psscan_flag (psscan_flag),
        .dtcref_phase(dtcref_phase),
        .eye_width   (eye_width),
        .scan_fail   (scan_fail),
        .ps_timeout  (ps_timeout)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    exp_t        sb_q[$];
    int          n_psen = 0;
    logic        last_dir = 1'b0;
    logic        hold = 1'b0;
    int          done_cnt = 0;
    logic [15:0] mdl_phase = '0;
    logic [15:0] scan_base = '0;
    logic [15:0] pass_mask = '0;
    int          glitch_pos = -1;
    int          settle_glitch_pos = -1;
    int          since = 0;
    logic        mon_en = 1'b1;
    int          op_id = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // MMCM + deserialiser model: psdone three cycles after each psen; data depends on position.
    initial begin
        logic        flag_seen;
        logic [3:0]  rel;
        logic [15:0] w0, w1;
        flag_seen = 1'b0;
        ps_if.psdone = 1'b0;
        forever begin
            @(negedge clk);
            ps_if.psdone = 1'b0;
            since++;
            if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) begin
                    ps_if.psdone = 1'b1;
                    mdl_phase = last_dir ? mdl_phase + 16'd1 : mdl_phase - 16'd1;
                    since = 0;
                    if (psscan_flag && !reset) check("psincdec_held", 64'(ps_if.psincdec), 64'(last_dir));
                end
            end else if (ps_if.psen) begin
                n_psen++;
                last_dir = ps_if.psincdec;
                if (!hold) done_cnt = 3;
            end
            if (psscan_flag && !flag_seen) since = 1;
            flag_seen = psscan_flag;
            rel = 4'(mdl_phase - scan_base);
            w0 = pass_mask[rel] ? PAT : ~PAT;
            w1 = w0;
            if (int'(rel) == glitch_pos && since == SETTLE + 4) w1 = ~PAT;
            if (int'(rel) == settle_glitch_pos && since == 2) begin
                w0 = ~PAT;
                w1 = ~PAT;
            end
            deser_dout = {w1, w0};
        end
    end

    // Monitor: one scoreboard entry per completed operation.
    initial begin
        logic mon_prev;
        int   busy;
        int   since_psen;
        exp_t e;
        mon_prev = 1'b0;
        busy = 0;
        since_psen = 0;
        forever begin
            @(negedge clk);
            if (ps_if.psen) since_psen = 0;
            else since_psen++;
            if (psscan_flag && !mon_prev) busy = 0;
            if (psscan_flag) busy++;
            if (mon_prev && !psscan_flag && mon_en) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got completion, expected none queued");
                end else begin
                    e = sb_q.pop_front();
                    op_id++;
                    $display("op %0d done: phase=%0d eye=%0d scan_fail=%0d psen=%0d dir=%0d tmo=%0d busy=%0d",
                             op_id, dtcref_phase, eye_width, scan_fail, n_psen, last_dir, ps_timeout, busy);
                    check("dtcref_phase", 64'(dtcref_phase), 64'(e.phase));
                    check("eye_width", 64'(eye_width), 64'(e.eye));
                    check("scan_fail", 64'(scan_fail), 64'(e.fail));
                    check("psen_count", 64'(n_psen), 64'(e.npsen));
                    check("psincdec", 64'(last_dir), 64'(e.dir));
                    check("ps_timeout", 64'(ps_timeout), 64'(e.tmo));
                    if (e.busy != 0) check("busy_cycles", 64'(busy), 64'(e.busy));
                    if (e.tmo != 0) check("timeout_latency", 64'(since_psen), 64'd1025);
                end
            end
            mon_prev = psscan_flag;
        end
    end

    task automatic run_op(input logic mode, input logic [15:0] step, input logic [15:0] mask,
                          input int gpos, input int sgpos, input bit poke, input exp_t e);
        @(negedge clk);
        pass_mask = mask;
        glitch_pos = gpos;
        settle_glitch_pos = sgpos;
        scan_base = mdl_phase;
        n_psen = 0;
        sb_q.push_back(e);
        psmode = mode;
        psstep = step;
        pscmd = 1'b1;
        @(negedge clk);
        pscmd = 1'b0;
        if (poke) begin
            repeat (4) @(negedge clk);
            psstep = 16'h8003;
            pscmd = 1'b1;
            @(negedge clk);
            pscmd = 1'b0;
        end
        for (int i = 0; i < 3000 && sb_q.size() != 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL op_timeout: got no completion, expected psscan_flag to fall");
            sb_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_psen"}, 64'(ps_if.psen), 64'd0);
        check({tag, "_psincdec"}, 64'(ps_if.psincdec), 64'd0);
        check({tag, "_flag"}, 64'(psscan_flag), 64'd0);
        check({tag, "_phase"}, 64'(dtcref_phase), 64'd0);
        check({tag, "_eye"}, 64'(eye_width), 64'd0);
        check({tag, "_scan_fail"}, 64'(scan_fail), 64'd0);
        check({tag, "_timeout"}, 64'(ps_timeout), 64'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        run_op(1'b0, 16'h0005, '0, -1, -1, 1'b1,
               '{phase:5, eye:0, fail:0, npsen:5, dir:1, tmo:0, busy:0});
        run_op(1'b0, 16'h8003, '0, -1, -1, 1'b0,
               '{phase:2, eye:0, fail:0, npsen:3, dir:0, tmo:0, busy:0});
        run_op(1'b0, 16'h0000, '0, -1, -1, 1'b0,
               '{phase:2, eye:0, fail:0, npsen:0, dir:0, tmo:0, busy:1});
        run_op(1'b1, 16'h0000, 16'h03E0, -1, -1, 1'b0,
               '{phase:25, eye:5, fail:0, npsen:23, dir:1, tmo:0, busy:0});
        run_op(1'b1, 16'h0000, 16'hC007, -1, -1, 1'b0,
               '{phase:41, eye:5, fail:0, npsen:16, dir:1, tmo:0, busy:0});
        run_op(1'b1, 16'h0000, 16'h0000, -1, -1, 1'b0,
               '{phase:57, eye:0, fail:1, npsen:16, dir:1, tmo:0, busy:0});
        run_op(1'b1, 16'h0000, 16'h0FFC, 6, 3, 1'b0,
               '{phase:82, eye:5, fail:0, npsen:25, dir:1, tmo:0, busy:0});
        run_op(1'b1, 16'h0000, 16'hFFFF, -1, -1, 1'b0,
               '{phase:106, eye:16, fail:0, npsen:24, dir:1, tmo:0, busy:0});
`ifdef DPS_TIMEOUT_EN
        hold = 1'b1;
        run_op(1'b0, 16'h0001, '0, -1, -1, 1'b0,
               '{phase:106, eye:16, fail:0, npsen:1, dir:1, tmo:1, busy:0});
        hold = 1'b0;
`endif

        // Reset in the middle of a scan, with a psdone still in flight afterwards.
        mon_en = 1'b0;
        pass_mask = 16'hFFFF;
        scan_base = mdl_phase;
        n_psen = 0;
        @(negedge clk);
        psmode = 1'b1;
        pscmd = 1'b1;
        @(negedge clk);
        pscmd = 1'b0;
        for (int i = 0; i < 500 && n_psen < 2; i++) @(negedge clk);
        check("midscan_psen_seen", 64'(n_psen >= 2), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("midreset");
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("post_reset_phase", 64'(dtcref_phase), 64'd0);
        check("post_reset_flag", 64'(psscan_flag), 64'd0);
        mon_en = 1'b1;

        run_op(1'b0, 16'h0002, '0, -1, -1, 1'b0,
               '{phase:2, eye:0, fail:0, npsen:2, dir:1, tmo:0, busy:0});
        run_op(1'b0, 16'h8005, '0, -1, -1, 1'b0,
               '{phase:65533, eye:0, fail:0, npsen:5, dir:0, tmo:0, busy:0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL global_timeout: got no finish, expected end within 60000 cycles");
        $fatal(1, "simulation deadline reached");
    end

endmodule

// File: doc/dps_eye_scan.md
# dps_eye_scan

Parametrised dynamic phase-shift controller for the SRU deserialiser clock MMCM. It drives the MMCM PSEN/PSINCDEC/PSDONE port in two modes. Step mode makes a signed manual shift. Scan mode sweeps one full period, checks a training pattern on NCH deserialiser channels at every position, finds the widest passing eye (wrap-around aware) and parks the clock at its centre. It sits between the register FSM (pscmd/psmode/psstep) and the clock generator, in the psclk domain.

## Interface
- NCH, 1: number of deserialiser channels checked
- PW, 16: pattern word width per channel
- PATTERN, 16'hF0F0: expected word on every channel during training
- SCAN_RANGE, 448: fine steps per period; also the number of sampled positions; 2..32767
- SETTLE_CYC, 16: wait cycles after psdone before sampling
- SAMPLE_CYC, 64: consecutive compare cycles per position
- psclk  in  1  clock; all logic rising-edge
- reset  in  1  synchronous, active-high
- pscmd  in  1  start pulse; ignored while busy
- psmode  in  1  0 = step, 1 = scan
- psstep  in  16  step mode: [15] direction (1 = decrement), [14:0] magnitude
- deser_dout  in  NCH*PW  deserialised words, channel c at [c*PW +: PW]
- psdone  in  1  MMCM step-complete pulse
- psen  out  1  one-cycle step request
- psincdec  out  1  step direction (1 = increment)
- psscan_flag  out  1  busy
- dtcref_phase  out  16  current phase position in steps, mod 2^16
- eye_width  out  16  last scan's best window length in positions
- scan_fail  out  1  last scan found no passing position
- ps_timeout  out  1  psdone watchdog fired (only with DPS_TIMEOUT_EN)

## Operation
- States: IDLE, STEP_REQ, STEP_WAIT, SETTLE, SAMPLE, EVAL, MOVE_REQ, MOVE_WAIT.
- Reset values: all outputs 0; state IDLE.
- IDLE: on pscmd, psscan_flag goes to 1.
  - Step mode with magnitude 0: psscan_flag drops the next cycle and no psen is issued.
  - Step mode with magnitude > 0: go to MOVE_REQ with `psincdec = ~psstep[15]` and the magnitude as the count.
  - Scan mode: clear the window tracker, set position index p = 0, go to SETTLE.
- SETTLE: count SETTLE_CYC cycles, then go to SAMPLE.
- SAMPLE: for SAMPLE_CYC cycles, AND together the per-cycle result "every channel word == PATTERN". Any mismatch fails position p. Feed pass/fail to the tracker. Then go to STEP_REQ (psincdec = 1).
- STEP_REQ → STEP_WAIT → on psdone: p++.
  - If p < SCAN_RANGE, go to SETTLE.
  - Otherwise go to EVAL. The phase is now at offset SCAN_RANGE, which equals offset 0.
- EVAL: the tracker reports the longest pass run.
  - A run touching position SCAN_RANGE-1 is merged with a run starting at position 0.
  - Ties go to the earliest start.
  - If every position passes, the width is SCAN_RANGE and the centre is SCAN_RANGE/2.
  - Otherwise centre = (start + width/2) mod SCAN_RANGE.
  - Update eye_width. scan_fail = (width == 0).
  - Fail: finish with no move; the phase stays at the original position.
  - Pass: MOVE centre increments; centre 0 finishes directly.
- MOVE_REQ/MOVE_WAIT: issue a psen pulse, wait for psdone, decrement the count, repeat until 0, then go to IDLE.
- dtcref_phase changes by ±1 on every accepted psdone and wraps mod 2^16.
- psdone outside a WAIT state is ignored.
- Reset mid-operation returns to IDLE with all outputs 0. The caller must reset the MMCM too.

## Timing
- pscmd sampled high in cycle N gives psscan_flag = 1 and psen = 1 in N+1 (step mode), or SETTLE starting in N+1 (scan mode).
- psen is high exactly one cycle per step. psincdec is valid in that cycle and held until psdone.
- psdone in cycle M updates dtcref_phase in M+1. The next psen comes no earlier than M+1 (move) or M+1+SETTLE_CYC+SAMPLE_CYC (scan).
- EVAL takes 1 cycle. psscan_flag falls the cycle after the last psdone is processed.

## Configuration
- DPS_TIMEOUT_EN defined: in any WAIT state, 1024 cycles without psdone sets ps_timeout, which is sticky until reset or the next pscmd. The operation aborts to IDLE with no further psen.
- DPS_TIMEOUT_EN not defined: waits are unbounded and ps_timeout is tied 0.

## Structure
- Package dps_pkg: the state enum, the 10-bit watchdog constant 1024, and the position-width localparam $clog2(SCAN_RANGE+1).
- Sub-module dps_win_track does run-length tracking:
  - Inputs: clear, valid, pass, last.
  - Outputs: best_start, best_width, first_run_len, cur_run_len.
  - It performs the wrap merge combinationally on last.

## Test plan
- Step mode, psstep = 16'h0005, psdone 3 cycles after each psen → 5 psen pulses, psincdec = 1, dtcref_phase = 5, then psscan_flag = 0.
- Step mode, psstep = 16'h8003 after the previous test → psincdec = 0, dtcref_phase = 2.
- Scan with SCAN_RANGE = 16, model passing positions 5..9 → eye_width = 5, centre 7, dtcref_phase ends at 16 + 7 = 23, scan_fail = 0.
- Scan, passing positions 14,15,0,1,2 → merged eye_width = 5, centre 0, no move steps, dtcref_phase = 16.
- Scan with the pattern always wrong → scan_fail = 1, eye_width = 0, exactly 16 psen pulses.
- DPS_TIMEOUT_EN defined, psdone withheld → ps_timeout = 1 at 1024 cycles, psscan_flag = 0. Then assert reset mid-scan → all outputs 0 the next cycle.
